// File: rtl/button_conditioner.sv
// Four-button conditioner. Each raw active-low button goes through a two-flop
// synchronizer and its own debounce counter. A registered edge stage then
// produces the debounced level plus press, release and auto-repeat pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_A,
    input  logic       btn_B,
    input  logic       btn_C,
    input  logic       btn_D,
    output logic [3:0] pressed,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] repeat_pulse,
    output logic       any_press
);

    // Debounce count runs 0..DEBOUNCE_CYCLES-1 only, so it cannot wrap.
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [CW-1:0] C_LAST      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    // Auto-repeat phase: released, waiting for the first repeat, periodic repeat.
    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_DELAY,
        HOLD_PERIOD
    } hold_state_e;

    logic [3:0] raw_n;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    assign raw_n = {btn_D, btn_C, btn_B, btn_A};

    // Two-flop synchronizer; reset value 1 means "released" for active-low buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic          sample;
            logic          s_q;
            logic          s_d;
            logic [CW-1:0] c_q;
            logic [CW-1:0] c_d;

            hold_state_e   state_q;
            logic [HW-1:0] h_q;
            logic          pressed_q;
            logic          press_q;
            logic          release_q;
            logic          repeat_q;

            // Stable state is kept active-high (1 = pressed).
            assign sample = ~sync2_q[gi];

            // Debounce: count consecutive samples that disagree with S, flip S on the last one.
            always_comb begin
                s_d = s_q;
                c_d = c_q;
                if (sample == s_q) begin
                    c_d = '0;
                end else if (c_q == C_LAST) begin
                    s_d = ~s_q;
                    c_d = '0;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end

            // Debounce state registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s_q <= 1'b0;
                    c_q <= '0;
                end else begin
                    s_q <= s_d;
                    c_q <= c_d;
                end
            end

            // Edge and auto-repeat FSM; level and pulses update on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= HOLD_IDLE;
                    h_q       <= '0;
                    pressed_q <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    repeat_q  <= 1'b0;
                end else begin
                    pressed_q <= s_q;
                    press_q   <= s_q & ~pressed_q;
                    release_q <= ~s_q & pressed_q;
                    repeat_q  <= 1'b0;
                    case (state_q)
                        HOLD_IDLE: begin
                            h_q <= '0;
                            if (s_q) begin
                                state_q  <= HOLD_DELAY;
                                repeat_q <= 1'b1;
                            end
                        end
                        HOLD_DELAY: begin
                            if (!s_q) begin
                                state_q <= HOLD_IDLE;
                                h_q     <= '0;
                            end else if (h_q == DELAY_LAST) begin
                                state_q  <= HOLD_PERIOD;
                                h_q      <= '0;
                                repeat_q <= 1'b1;
                            end else begin
                                h_q <= h_q + 1'b1;
                            end
                        end
                        HOLD_PERIOD: begin
                            if (!s_q) begin
                                state_q <= HOLD_IDLE;
                                h_q     <= '0;
                            end else if (h_q == PERIOD_LAST) begin
                                h_q      <= '0;
                                repeat_q <= 1'b1;
                            end else begin
                                h_q <= h_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= HOLD_IDLE;
                            h_q     <= '0;
                        end
                    endcase
                end
            end

            assign pressed[gi]       = pressed_q;
            assign press_pulse[gi]   = press_q;
            assign release_pulse[gi] = release_q;
            assign repeat_pulse[gi]  = repeat_q;
        end
    endgenerate

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts
// every output each cycle, a monitor compares, plus directed timing masks.
module tb_button_conditioner;

    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 4000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_A = 1'b1, btn_B = 1'b1, btn_C = 1'b1, btn_D = 1'b1;
    logic [3:0] pressed, press_pulse, release_pulse, repeat_pulse;
    logic       any_press;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_A(btn_A),
        .btn_B(btn_B),
        .btn_C(btn_C),
        .btn_D(btn_D),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [16:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state: pressed-sense sample history per button.
    bit   p_h[4][MAXC];
    bit   stable_m[4];
    bit   prev_m[4];
    int   tp_m[4];
    bit   obs_rep[MAXC];
    bit   obs_press[MAXC];

    function automatic bit ph(int b, int j);
        if (j < 0) return 1'b0;
        return p_h[b][j];
    endfunction

    // Level changes once the sample two edges back has held a new value for D samples;
    // outputs lag the stable level by one edge; repeats follow press time arithmetic.
    task automatic model_step(input logic [3:0] raw, input bit rst, output logic [16:0] vec);
        logic [3:0] e_pr, e_ps, e_rl, e_rp;
        bit v, all_same, pout;
        e_pr = '0; e_ps = '0; e_rl = '0; e_rp = '0;
        for (int b = 0; b < 4; b++) begin
            p_h[b][cyc] = rst ? 1'b0 : ~raw[b];
            if (rst && cyc > 0) p_h[b][cyc-1] = 1'b0;
            if (rst) begin
                stable_m[b] = 1'b0;
                prev_m[b]   = 1'b0;
            end else begin
                pout = stable_m[b];
                v = ph(b, cyc - 2);
                all_same = 1'b1;
                for (int i = 0; i < D; i++)
                    if (ph(b, cyc - 2 - i) != v) all_same = 1'b0;
                if (v != stable_m[b] && all_same) stable_m[b] = v;
                e_pr[b] = pout;
                e_ps[b] = pout && !prev_m[b];
                e_rl[b] = !pout && prev_m[b];
                if (e_ps[b]) tp_m[b] = cyc;
                e_rp[b] = pout && ((cyc == tp_m[b]) ||
                          ((cyc - tp_m[b] >= RD) && ((cyc - tp_m[b] - RD) % RP == 0)));
                prev_m[b] = pout;
            end
        end
        vec = {|e_ps, e_rp, e_rl, e_ps, e_pr};
    endtask

    task automatic step(input logic [3:0] raw, input bit rst);
        logic [16:0] v;
        exp_t e;
        @(negedge clk);
        {btn_D, btn_C, btn_B, btn_A} = raw;
        reset = rst;
        model_step(raw, rst, v);
        e.cyc = cyc;
        e.vec = v;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    // Monitor: compare every DUT output set against the queued prediction.
    initial begin
        exp_t e;
        logic [16:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {any_press, repeat_pulse, release_pulse, press_pulse, pressed};
                obs_rep[e.cyc]   = repeat_pulse[0];
                obs_press[e.cyc] = press_pulse[0];
                total++;
                if (act !== e.vec) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got any/rep/rel/prs/lvl=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                             e.cyc, act[16], act[15:12], act[11:8], act[7:4], act[3:0],
                             e.vec[16], e.vec[15:12], e.vec[11:8], e.vec[7:4], e.vec[3:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s29, s32, waited;
        logic [3:0]  raw_r;
        logic [30:0] exp29, got29;
        logic [15:0] exp32, got32;
        for (int b = 0; b < 4; b++) tp_m[b] = -100000;

        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        hold(4'hF, 5);
        $display("phase reset_idle cycles=%0d", cyc);

        s29 = cyc;
        hold(4'hE, 31);
        hold(4'hF, 12);
        $display("phase hold_repeat_release start=%0d", s29);

        hold(4'hD, 3);
        hold(4'hF, 10);
        $display("phase glitch_b cycles=%0d", cyc);

        hold(4'h3, 12);
        hold(4'hF, 10);
        $display("phase simultaneous_cd cycles=%0d", cyc);

        s32 = cyc;
        hold(4'hE, 4);
        step(4'hE, 1'b1);
        hold(4'hE, 11);
        hold(4'hF, 12);
        $display("phase reset_mid_press start=%0d", s32);

        raw_r = 4'hF;
        for (int n = 0; n < 1600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(n < 800 ? 5 : 39) == 0) raw_r[b] = ~raw_r[b];
            step(raw_r, $urandom_range(199) == 0);
        end
        $display("phase random cycles=%0d", cyc);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want 0", sb_q.size());
        end

        exp29 = '0;
        exp29[6] = 1'b1; exp29[16] = 1'b1; exp29[19] = 1'b1;
        exp29[22] = 1'b1; exp29[25] = 1'b1; exp29[28] = 1'b1;
        for (int e = 0; e <= 30; e++) got29[e] = obs_rep[s29 + e];
        total++;
        if (got29 !== exp29) begin
            bad++;
            $display("FAIL repeat_edges got %b want %b", got29, exp29);
        end

        exp32 = '0;
        exp32[11] = 1'b1;
        for (int e = 0; e < 16; e++) got32[e] = obs_press[s32 + e];
        total++;
        if (got32 !== exp32) begin
            bad++;
            $display("FAIL reset_press_edge got %b want %b", got32, exp32);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
